booth_r4_mult: RTL and testbench

Sequential radix-4 (modified Booth) multiplier, parametrised in operand width, with a signed/unsigned mode and a start/done handshake. It retires two multiplier bits per clock, so it runs in roughly half the cycles of the single-bit add-and-shift datapath. It is the multiplier core of the arithmetic unit and is driven by the top-level controller or testbench.

---
 rtl/booth_r4_pkg.sv | 27 ++
 rtl/booth_r4_mult_if.sv | 25 ++
 rtl/booth_r4_addsub.sv | 19 +
 rtl/booth_r4_recoder.sv | 21 ++
 rtl/booth_r4_mult.sv | 134 +++++++++++++
 tb/tb_booth_r4_mult.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/booth_r4_pkg.sv
// booth_r4_pkg
// Shared definitions for the radix-4 Booth multiplier: FSM states,
// recoded Booth digits and the internal-width helper.
package booth_r4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PLUS_M,
        PLUS_2M,
        MINUS_M,
        MINUS_2M
    } digit_e;

    // Internal datapath width. The two extra bits let unsigned operands
    // ride through the signed Booth datapath as positive numbers.
    function automatic int W(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// booth_r4_mult_if
// Start/done handshake and operand/result bus of the Booth multiplier.
//   start, signed_mode, multiplicand, multiplier : master -> slave
//   busy, done, product                          : slave -> master
interface booth_r4_mult_if #(
    parameter int N = 8
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_addsub.sv
// booth_r4_addsub
// Parameterised adder/subtractor: sum_o = a_i + b_i, or a_i - b_i when sub_i.
//   a_i, b_i : WIDTH-bit operands
//   sub_i    : 1 = subtract (two's complement of b_i)
//   sum_o    : WIDTH-bit result (wraps)
//   cout_o   : carry out of the top bit
module booth_r4_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i}
                           + {1'b0, b_i ^ {WIDTH{sub_i}}}
                           + {{WIDTH{1'b0}}, sub_i};
endmodule

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder
// Combinational radix-4 Booth recoder.
//   bits_i  : {q1, q0, q_m1} window of the multiplier
//   digit_o : selected digit (0, +-M, +-2M)
module booth_r4_recoder
    import booth_r4_pkg::*;
(
    input  logic [2:0] bits_i,
    output digit_e     digit_o
);
    always_comb begin
        digit_o = ZERO;
        case (bits_i)
            3'b001, 3'b010: digit_o = PLUS_M;
            3'b011:         digit_o = PLUS_2M;
            3'b100:         digit_o = MINUS_2M;
            3'b101, 3'b110: digit_o = MINUS_M;
            default:        digit_o = ZERO;
        endcase
    end
endmodule

// File: rtl/booth_r4_mult.sv
// booth_r4_mult
// Sequential radix-4 (modified Booth) multiplier, two multiplier bits per
// clock, signed or unsigned operands, start/done handshake.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : booth_r4_mult_if slave (start/operands in, busy/done/product out)
module booth_r4_mult
    import booth_r4_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          reset,
    booth_r4_mult_if.slave bus
);
    localparam int WI = W(N);          // extended operand width
    localparam int AW = WI + 2;        // accumulator, headroom for +-2M
    localparam int CW = $clog2(WI / 2 + 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [WI-1:0]    m_q, m_d;
    logic [WI-1:0]    qr_q, qr_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;

    digit_e           digit;
    logic [AW-1:0]    m_sx;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic             sub;
    logic             unused_cout;
    logic [WI-1:0]    m_ext, q_ext;
    logic             take;

    // Unsigned operands are zero-extended so they look positive to the
    // signed datapath; the product still fits in 2N bits either way.
    assign m_ext = bus.signed_mode ? {{2{bus.multiplicand[N-1]}}, bus.multiplicand}
                                   : {2'b00, bus.multiplicand};
    assign q_ext = bus.signed_mode ? {{2{bus.multiplier[N-1]}}, bus.multiplier}
                                   : {2'b00, bus.multiplier};

    booth_r4_recoder u_rec (
        .bits_i  ({qr_q[1:0], qm1_q}),
        .digit_o (digit)
    );

    assign m_sx = {{2{m_q[WI-1]}}, m_q};

    always_comb begin
        addend = '0;
        sub    = 1'b0;
        case (digit)
            PLUS_M:   addend = m_sx;
            PLUS_2M:  addend = m_sx << 1;
            MINUS_M:  begin addend = m_sx;      sub = 1'b1; end
            MINUS_2M: begin addend = m_sx << 1; sub = 1'b1; end
            default:  addend = '0;
        endcase
    end

    booth_r4_addsub #(.WIDTH(AW)) u_add (
        .a_i    (a_q),
        .b_i    (addend),
        .sub_i  (sub),
        .sum_o  (sum),
        .cout_o (unused_cout)
    );

    // Operands are accepted only when idle or in the done cycle.
    assign take = bus.start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: state_d = IDLE;
            LOAD: state_d = CALC;
            CALC: begin
                // Add the digit, then arithmetic shift {A,Q,q_m1} right by 2.
                a_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
                qr_d  = {sum[1:0], qr_q[WI-1:2]};
                qm1_d = qr_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WI / 2 - 1)) begin
                    state_d = DONE;
                    // Product is captured on the edge that enters DONE.
                    prod_d  = {a_d[N-3:0], qr_d};
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = LOAD;
            a_d     = '0;
            m_d     = m_ext;
            qr_d    = q_ext;
            qm1_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = (state_q == LOAD) || (state_q == CALC);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// tb_booth_r4_mult
// Self-checking bench: N=8 directed table, hand-written corner sequences,
// and back-to-back random sweeps at N=4, 8 and 16 against an arithmetic
// reference model.
module tb_booth_r4_mult;
    logic clk;
    logic reset;

    booth_r4_mult_if #(.N(4))  if4 ();
    booth_r4_mult_if #(.N(8))  if8 ();
    booth_r4_mult_if #(.N(16)) if16 ();

    booth_r4_mult #(.N(4))  u4  (.clk(clk), .reset(reset), .bus(if4));
    booth_r4_mult #(.N(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
    booth_r4_mult #(.N(16)) u16 (.clk(clk), .reset(reset), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    // Reference: interpret operands per mode, multiply, keep 2n bits.
    function automatic logic [31:0] ref_mul(int n, logic sm, logic [15:0] a, logic [15:0] b);
        longint      sa, sb, p;
        logic [63:0] pm, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[n-1]) sa = sa - (longint'(1) << n);
        if (sm && b[n-1]) sb = sb - (longint'(1) << n);
        p    = sa * sb;
        pm   = p;
        mask = (64'd1 << (2 * n)) - 64'd1;
        return 32'(pm & mask);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(int n, logic st, logic sm, logic [15:0] a, logic [15:0] b);
        case (n)
            4: begin if4.start = st; if4.signed_mode = sm; if4.multiplicand = a[3:0]; if4.multiplier = b[3:0]; end
            8: begin if8.start = st; if8.signed_mode = sm; if8.multiplicand = a[7:0]; if8.multiplier = b[7:0]; end
            default: begin if16.start = st; if16.signed_mode = sm; if16.multiplicand = a; if16.multiplier = b; end
        endcase
    endtask

    function automatic logic get_done(int n);
        return (n == 4) ? if4.done : (n == 8) ? if8.done : if16.done;
    endfunction

    function automatic logic get_busy(int n);
        return (n == 4) ? if4.busy : (n == 8) ? if8.busy : if16.busy;
    endfunction

    function automatic logic [31:0] get_prod(int n);
        return (n == 4) ? 32'(if4.product) : (n == 8) ? 32'(if8.product) : 32'(if16.product);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done (bounded); lat counts edges including the start edge.
    task automatic wait_done(int n, string name, inout int lat);
        while (!get_done(n) && lat < 60) begin
            tick();
            lat++;
        end
        if (!get_done(n)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got done=0 expected done=1", name);
        end
    endtask

    // Single operation with start pulsed for one edge.
    task automatic run_one(int n, logic sm, logic [15:0] a, logic [15:0] b, string name);
        int lat;
        logic [31:0] exp;
        exp = ref_mul(n, sm, a, b);
        set_ops(n, 1'b1, sm, a, b);
        tick();
        lat = 1;
        set_ops(n, 1'b0, sm, a, b);
        chk({name, " busy"}, 32'(get_busy(n)), 32'd1);
        wait_done(n, name, lat);
        chk({name, " latency"}, lat, n / 2 + 3);
        chk({name, " product"}, get_prod(n), exp);
        chk({name, " busy@done"}, 32'(get_busy(n)), 32'd0);
        tick();
        chk({name, " done width"}, 32'(get_done(n)), 32'd0);
        chk({name, " hold"}, get_prod(n), exp);
    endtask

    // start held high; new random operands presented in each done cycle.
    task automatic b2b(int n, int nops);
        logic [15:0] a, b, mask;
        logic        sm;
        logic [31:0] exp;
        int          lat;
        mask = 16'((32'd1 << n) - 1);
        a  = 16'($urandom) & mask;
        b  = 16'($urandom) & mask;
        sm = 1'($urandom);
        exp = ref_mul(n, sm, a, b);
        set_ops(n, 1'b1, sm, a, b);
        for (int i = 0; i < nops; i++) begin
            tick();
            lat = 1;
            wait_done(n, $sformatf("b2b n=%0d #%0d", n, i), lat);
            chk($sformatf("b2b n=%0d #%0d interval", n, i), lat, n / 2 + 3);
            chk($sformatf("b2b n=%0d #%0d product sm=%0d %0h*%0h", n, i, sm, a, b),
                get_prod(n), exp);
            a  = 16'($urandom) & mask;
            b  = 16'($urandom) & mask;
            sm = 1'($urandom);
            exp = ref_mul(n, sm, a, b);
            set_ops(n, (i < nops - 1), sm, a, b);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   lat;

        vecs.push_back('{"s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000});
        vecs.push_back('{"s 7*-3",      1'b1, 8'h07, 8'hFD, 16'hFFEB});
        vecs.push_back('{"u 255*255",   1'b0, 8'hFF, 8'hFF, 16'hFE01});
        vecs.push_back('{"s 0*-1",      1'b1, 8'h00, 8'hFF, 16'h0000});
        vecs.push_back('{"u 1*128",     1'b0, 8'h01, 8'h80, 16'h0080});
        vecs.push_back('{"s -128*127",  1'b1, 8'h80, 8'h7F, 16'hC080});
        vecs.push_back('{"u 128*128",   1'b0, 8'h80, 8'h80, 16'h4000});
        vecs.push_back('{"s -1*-1",     1'b1, 8'hFF, 8'hFF, 16'h0001});

        reset = 1'b1;
        set_ops(4, 1'b0, 1'b0, 16'h0, 16'h0);
        set_ops(8, 1'b0, 1'b0, 16'h0, 16'h0);
        set_ops(16, 1'b0, 1'b0, 16'h0, 16'h0);
        #22;
        chk("reset busy",    32'(if8.busy), 32'd0);
        chk("reset done",    32'(if8.done), 32'd0);
        chk("reset product", 32'(if8.product), 32'd0);
        reset = 1'b0;
        tick();

        // Directed table; expected values written out by hand.
        foreach (vecs[i]) begin
            set_ops(8, 1'b1, vecs[i].sm, 16'(vecs[i].a), 16'(vecs[i].b));
            tick();
            lat = 1;
            set_ops(8, 1'b0, vecs[i].sm, 16'(vecs[i].a), 16'(vecs[i].b));
            wait_done(8, vecs[i].name, lat);
            chk({vecs[i].name, " latency"}, lat, 7);
            chk({vecs[i].name, " product"}, 32'(if8.product), 32'(vecs[i].exp));
            chk({vecs[i].name, " busy@done"}, 32'(if8.busy), 32'd0);
            tick();
            chk({vecs[i].name, " done width"}, 32'(if8.done), 32'd0);
        end

        // start re-asserted with other operands during CALC is ignored.
        set_ops(8, 1'b1, 1'b1, 16'h07, 16'hFD);
        tick(); lat = 1;
        set_ops(8, 1'b0, 1'b1, 16'h07, 16'hFD);
        tick(); lat++;
        tick(); lat++;
        set_ops(8, 1'b1, 1'b0, 16'h64, 16'h64);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ignore busy %0d", i), 32'(if8.busy), 32'd1);
            tick(); lat++;
        end
        set_ops(8, 1'b0, 1'b0, 16'h64, 16'h64);
        wait_done(8, "ignore", lat);
        chk("ignore latency", lat, 7);
        chk("ignore product", 32'(if8.product), 32'hFFEB);
        tick();

        // Reset mid-CALC clears outputs asynchronously.
        set_ops(8, 1'b1, 1'b0, 16'h33, 16'h21);
        tick();
        set_ops(8, 1'b0, 1'b0, 16'h33, 16'h21);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midreset busy",    32'(if8.busy), 32'd0);
        chk("midreset done",    32'(if8.done), 32'd0);
        chk("midreset product", 32'(if8.product), 32'd0);
        #1 reset = 1'b0;
        tick();
        run_one(8, 1'b1, 16'h9C, 16'h4B, "after reset");

        // N=8 back-to-back, then wider/narrower random sweeps.
        b2b(8, 8);
        b2b(4, 40);
        b2b(16, 40);
        run_one(16, 1'b1, 16'h8000, 16'h8000, "n16 min*min");
        run_one(4, 1'b0, 16'hF, 16'hF, "n4 15*15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
